// File: rtl/qdma_mailbox_mc_fifo.sv
// rtl/qdma_mailbox_mc_fifo.sv - multi-channel mailbox FIFO, NUM_CH queues in one shared RAM
module qdma_mailbox_mc_fifo #(
    parameter int DATA_W = 256,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic                    clkin,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       flush,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    output logic [DATA_W-1:0]       rd_data,
    input  logic [CNT_W-1:0]        ae_thresh,
    input  logic [CNT_W-1:0]        af_thresh,
    input  logic                    err_clr,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       almost_empty,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       ovf_err,
    output logic [NUM_CH-1:0]       udf_err
);

    logic [DATA_W-1:0] ram [NUM_CH*DEPTH];

    logic [PTR_W-1:0]  wptr_q  [NUM_CH];
    logic [PTR_W-1:0]  wptr_d  [NUM_CH];
    logic [PTR_W-1:0]  rptr_q  [NUM_CH];
    logic [PTR_W-1:0]  rptr_d  [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] udf_q, udf_d;

    logic rd_ok, wr_ok, rd_acc, wr_acc, ovf_set, udf_set;

    // Acceptance is decided before flush; flush then silently cancels the access.
    always_comb begin
        rd_ok   = rd_en && (count_q[rd_ch] != '0);
        wr_ok   = wr_en && ((count_q[wr_ch] != CNT_W'(DEPTH)) || (rd_ok && (rd_ch == wr_ch)));
        rd_acc  = rd_ok && !flush[rd_ch];
        wr_acc  = wr_ok && !flush[wr_ch];
        ovf_set = wr_en && !wr_ok && !flush[wr_ch];
        udf_set = rd_en && !rd_ok && !flush[rd_ch];
    end

    always_comb begin
        ovf_d = err_clr ? '0 : ovf_q;
        udf_d = err_clr ? '0 : udf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_d[c]  = wptr_q[c];
            rptr_d[c]  = rptr_q[c];
            count_d[c] = count_q[c];
            if (wr_acc && (wr_ch == CH_W'(c))) begin
                wptr_d[c] = wptr_q[c] + 1'b1;
            end
            if (rd_acc && (rd_ch == CH_W'(c))) begin
                rptr_d[c] = rptr_q[c] + 1'b1;
            end
            if ((wr_acc && (wr_ch == CH_W'(c))) && !(rd_acc && (rd_ch == CH_W'(c)))) begin
                count_d[c] = count_q[c] + 1'b1;
            end else if (!(wr_acc && (wr_ch == CH_W'(c))) && (rd_acc && (rd_ch == CH_W'(c)))) begin
                count_d[c] = count_q[c] - 1'b1;
            end
            if (flush[c]) begin
                wptr_d[c]  = '0;
                rptr_d[c]  = '0;
                count_d[c] = '0;
            end
            // A fresh error outranks err_clr in the same cycle.
            if (ovf_set && (wr_ch == CH_W'(c))) begin
                ovf_d[c] = 1'b1;
            end
            if (udf_set && (rd_ch == CH_W'(c))) begin
                udf_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                count_q[c] <= count_d[c];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage is deliberately unreset; queue c lives at words c*DEPTH.. via {ch, ptr}.
    always_ff @(posedge clkin) begin
        if (wr_acc) begin
            ram[{wr_ch, wptr_q[wr_ch]}] <= wr_data;
        end
    end

    assign rd_data = ram[{rd_ch, rptr_q[rd_ch]}];
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

    always_comb begin
        count        = '0;
        empty        = '0;
        full         = '0;
        almost_empty = '0;
        almost_full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            count[c*CNT_W +: CNT_W] = count_q[c];
            empty[c]        = (count_q[c] == '0);
            full[c]         = (count_q[c] == CNT_W'(DEPTH));
            almost_empty[c] = (count_q[c] <= ae_thresh);
            almost_full[c]  = (count_q[c] >= af_thresh);
        end
    end

endmodule

// File: tb/tb_qdma_mailbox_mc_fifo.sv
// tb/tb_qdma_mailbox_mc_fifo.sv - directed self-checking bench for qdma_mailbox_mc_fifo
module tb_qdma_mailbox_mc_fifo;

    localparam int DATA_W = 256;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 5;

    logic                    clkin = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       flush;
    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic [DATA_W-1:0]       wr_data;
    logic                    rd_en;
    logic [CH_W-1:0]         rd_ch;
    logic [DATA_W-1:0]       rd_data;
    logic [CNT_W-1:0]        ae_thresh;
    logic [CNT_W-1:0]        af_thresh;
    logic                    err_clr;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       empty, full, almost_empty, almost_full, ovf_err, udf_err;

    int vectors = 0;
    int miscompares = 0;

    qdma_mailbox_mc_fifo dut (
        .clkin(clkin), .reset_n(reset_n), .flush(flush),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh), .err_clr(err_clr),
        .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clkin = ~clkin;

    function automatic logic [CNT_W-1:0] cnt(input int c);
        return count[c*CNT_W +: CNT_W];
    endfunction

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = '0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle(); wr_ch = '0; rd_ch = '0; wr_data = '0;
        ae_thresh = 5'd0; af_thresh = 5'd16;
        step(); step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (count !== '0) begin miscompares++; $display("FAIL reset_count got %h exp 0", count); end
        vectors++;
        if (empty !== 4'hF || almost_empty !== 4'hF) begin
            miscompares++; $display("FAIL reset_empty got e=%b ae=%b exp 1111/1111", empty, almost_empty);
        end
        vectors++;
        if (full !== 4'h0 || almost_full !== 4'h0 || ovf_err !== 4'h0 || udf_err !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_flags got f=%b af=%b ovf=%b udf=%b exp all 0", full, almost_full, ovf_err, udf_err);
        end
    endtask

    task automatic test_fill_ovf();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_ch = 2'd2; wr_data = DATA_W'(i);
            step();
        end
        wr_en = 1'b0;
        vectors++;
        if (cnt(2) !== 5'd16 || full[2] !== 1'b1) begin
            miscompares++; $display("FAIL fill_ch2 got cnt=%0d full=%b exp 16/1", cnt(2), full[2]);
        end
        wr_en = 1'b1; wr_data = DATA_W'(32'hDEAD);
        step();
        wr_en = 1'b0;
        vectors++;
        if (ovf_err !== 4'b0100 || cnt(2) !== 5'd16) begin
            miscompares++; $display("FAIL ovf_ch2 got ovf=%b cnt=%0d exp 0100/16", ovf_err, cnt(2));
        end
    endtask

    task automatic test_drain_udf();
        rd_ch = 2'd2;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (rd_data !== DATA_W'(i)) begin
                miscompares++; $display("FAIL drain_data[%0d] got %h exp %h", i, rd_data[31:0], i);
            end
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        vectors++;
        if (empty[2] !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b exp 1", empty[2]); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        vectors++;
        if (udf_err !== 4'b0100 || ovf_err !== 4'b0100) begin
            miscompares++; $display("FAIL udf_ch2 got udf=%b ovf=%b exp 0100/0100", udf_err, ovf_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++;
        if (udf_err !== 4'b0 || ovf_err !== 4'b0) begin
            miscompares++; $display("FAIL err_clr got udf=%b ovf=%b exp 0/0", udf_err, ovf_err);
        end
    endtask

    task automatic test_simul_wrap();
        wr_ch = 2'd1; rd_ch = 2'd1;
        for (int i = 0; i < 10; i++) begin wr_en = 1'b1; wr_data = DATA_W'(i); step(); end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin rd_en = 1'b1; step(); end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin wr_en = 1'b1; wr_data = DATA_W'(8'hA0 + i); step(); end
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (rd_data !== DATA_W'(8'hA0 + k)) begin
                miscompares++; $display("FAIL wrap_data[%0d] got %h exp %h", k, rd_data[31:0], 8'hA0 + k);
            end
            wr_en = 1'b1; wr_data = DATA_W'(8'hA3 + k); rd_en = 1'b1;
            step();
            vectors++;
            if (cnt(1) !== 5'd3) begin miscompares++; $display("FAIL wrap_cnt[%0d] got %0d exp 3", k, cnt(1)); end
        end
        wr_en = 1'b0;
        for (int k = 10; k < 13; k++) begin
            vectors++;
            if (rd_data !== DATA_W'(8'hA0 + k)) begin
                miscompares++; $display("FAIL wrap_tail[%0d] got %h exp %h", k, rd_data[31:0], 8'hA0 + k);
            end
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        vectors++;
        if (cnt(1) !== 5'd0 || ovf_err !== 4'b0 || udf_err !== 4'b0) begin
            miscompares++; $display("FAIL wrap_end got cnt=%0d ovf=%b udf=%b exp 0/0/0", cnt(1), ovf_err, udf_err);
        end
    endtask

    task automatic test_full_wr_rd();
        wr_ch = 2'd0;
        for (int i = 0; i < 16; i++) begin wr_en = 1'b1; wr_data = DATA_W'(12'h200 + i); step(); end
        wr_en = 1'b1; wr_data = DATA_W'(12'h2FF); rd_en = 1'b1; rd_ch = 2'd0;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (cnt(0) !== 5'd16 || ovf_err[0] !== 1'b0 || rd_data !== DATA_W'(12'h201)) begin
            miscompares++;
            $display("FAIL full_wrrd got cnt=%0d ovf=%b head=%h exp 16/0/201", cnt(0), ovf_err[0], rd_data[31:0]);
        end
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = DATA_W'(12'h300); rd_en = 1'b1; rd_ch = 2'd3;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (udf_err !== 4'b1000 || cnt(3) !== 5'd1 || rd_data !== DATA_W'(12'h300)) begin
            miscompares++;
            $display("FAIL empty_wrrd got udf=%b cnt=%0d head=%h exp 1000/1/300", udf_err, cnt(3), rd_data[31:0]);
        end
        flush = 4'b1001; err_clr = 1'b1;
        step();
        idle();
        vectors++;
        if (cnt(0) !== 5'd0 || cnt(3) !== 5'd0 || udf_err !== 4'b0) begin
            miscompares++; $display("FAIL flush03 got c0=%0d c3=%0d udf=%b exp 0/0/0", cnt(0), cnt(3), udf_err);
        end
    endtask

    task automatic test_thresh();
        ae_thresh = 5'd4; af_thresh = 5'd12; wr_ch = 2'd1;
        #1;
        vectors++;
        if (almost_empty[1] !== 1'b1 || almost_full[1] !== 1'b0) begin
            miscompares++; $display("FAIL thr_n0 got ae=%b af=%b exp 1/0", almost_empty[1], almost_full[1]);
        end
        for (int n = 1; n <= 12; n++) begin
            wr_en = 1'b1; wr_data = DATA_W'(n);
            step();
            vectors++;
            if (almost_empty[1] !== (n <= 4) || almost_full[1] !== (n >= 12)) begin
                miscompares++;
                $display("FAIL thr_n%0d got ae=%b af=%b exp %b/%b", n, almost_empty[1], almost_full[1], n <= 4, n >= 12);
            end
        end
        wr_en = 1'b0;
        af_thresh = 5'd13;
        #1;
        vectors++;
        if (almost_full[1] !== 1'b0) begin miscompares++; $display("FAIL thr_af13 got %b exp 0", almost_full[1]); end
        af_thresh = 5'd12;
        #1;
        vectors++;
        if (almost_full[1] !== 1'b1) begin miscompares++; $display("FAIL thr_af12 got %b exp 1", almost_full[1]); end
    endtask

    task automatic test_flush_err();
        flush = 4'b0010; wr_en = 1'b1; wr_ch = 2'd1; wr_data = DATA_W'(8'h55); rd_en = 1'b1; rd_ch = 2'd1;
        step();
        idle();
        vectors++;
        if (cnt(1) !== 5'd0 || ovf_err !== 4'b0 || udf_err !== 4'b0) begin
            miscompares++; $display("FAIL flush1 got cnt=%0d ovf=%b udf=%b exp 0/0/0", cnt(1), ovf_err, udf_err);
        end
        wr_ch = 2'd2;
        for (int i = 0; i < 16; i++) begin wr_en = 1'b1; wr_data = DATA_W'(12'h400 + i); step(); end
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = DATA_W'(12'h3AA); rd_en = 1'b1; rd_ch = 2'd2;
        step();
        idle();
        vectors++;
        if (cnt(2) !== 5'd15 || cnt(3) !== 5'd1 || rd_data !== DATA_W'(12'h401)) begin
            miscompares++;
            $display("FAIL b2b_split got c2=%0d c3=%0d head=%h exp 15/1/401", cnt(2), cnt(3), rd_data[31:0]);
        end
        wr_en = 1'b1; wr_ch = 2'd2; wr_data = DATA_W'(12'h410);
        step();
        rd_en = 1'b1; rd_ch = 2'd0; wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        vectors++;
        if (udf_err !== 4'b0001 || full[2] !== 1'b1) begin
            miscompares++; $display("FAIL udf_ch0 got udf=%b full2=%b exp 0001/1", udf_err, full[2]);
        end
        err_clr = 1'b1; wr_en = 1'b1; wr_ch = 2'd2;
        step();
        idle();
        vectors++;
        if (ovf_err !== 4'b0100 || udf_err !== 4'b0000) begin
            miscompares++; $display("FAIL clr_vs_ovf got ovf=%b udf=%b exp 0100/0000", ovf_err, udf_err);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++;
        if (count !== '0 || empty !== 4'hF || ovf_err !== 4'b0) begin
            miscompares++; $display("FAIL midreset got cnt=%h e=%b ovf=%b exp 0/1111/0", count, empty, ovf_err);
        end
    endtask

    initial begin
        test_reset();
        test_fill_ovf();
        test_drain_udf();
        test_simul_wrap();
        test_full_wr_rd();
        test_thresh();
        test_flush_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
